uart_cmd_ctrl: RTL and testbench

- Command sequencer behind the UART receiver.
- Consumes the byte stream (rx_data/rx_valid pulse) and parses framed commands: SYNC, CMD, ADDR, LEN, DATA[LEN], plus an optional CHK byte.
- Issues a valid/ready byte-write stream to the TPU host-register/buffer interface, or a one-cycle start pulse.
- Detects framing, length, timeout, overrun and checksum errors, and resynchronises on the next SYNC byte.

---
 rtl/uart_cmd_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses SYNC/CMD/ADDR/LEN/DATA[/CHK] UART frames into byte writes or a start pulse.
// Define UART_CMD_CHECKSUM_EN to buffer the payload, verify an XOR check byte, then burst the writes.
module uart_cmd_ctrl #(
    parameter int         TIMEOUT_CYCLES = 1_000_000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       start_pulse,
    output logic       frame_done,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy
);
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_START  = 8'h02;
    localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);
    localparam logic [2:0] E_BAD_CMD  = 3'd1;
    localparam logic [2:0] E_BAD_LEN  = 3'd2;
    localparam logic [2:0] E_TIMEOUT  = 3'd3;
    localparam logic [2:0] E_OVERRUN  = 3'd4;
    localparam int         TW         = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_LEN, S_DATA, S_CHK, S_ISSUE} state_t;

    state_t          state;
    logic            is_write;
    logic [7:0]      addr_ptr;
    logic [7:0]      cnt;
    logic [TW-1:0]   tcnt;
    logic            hs;
    logic            timed;
    logic            timeout_hit;

`ifdef UART_CMD_CHECKSUM_EN
    localparam logic [2:0] E_CHECKSUM = 3'd5;
    localparam int         IW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    logic [7:0] pay_buf [0:(1<<IW)-1];
    logic [7:0] chk;
    logic [7:0] len_q;

    always_ff @(posedge clk) begin
        if (state == S_DATA && rx_valid)
            pay_buf[cnt[IW-1:0]] <= rx_data;
    end
`endif

    assign hs          = wr_valid && wr_ready;
    assign timed       = (state == S_CMD) || (state == S_ADDR) || (state == S_LEN) ||
                         (state == S_DATA) || (state == S_CHK);
    assign timeout_hit = timed && !rx_valid && (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign busy        = (state != S_IDLE) || wr_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            wr_valid    <= 1'b0;
            wr_addr     <= 8'h00;
            wr_data     <= 8'h00;
            start_pulse <= 1'b0;
            frame_done  <= 1'b0;
            err_valid   <= 1'b0;
            err_code    <= 3'd0;
            is_write    <= 1'b0;
            addr_ptr    <= 8'h00;
            cnt         <= 8'h00;
            tcnt        <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            chk         <= 8'h00;
            len_q       <= 8'h00;
`endif
        end else begin
            start_pulse <= 1'b0;
            frame_done  <= 1'b0;
            err_valid   <= 1'b0;
            if (rx_valid || !timed) tcnt <= '0;
            else                    tcnt <= tcnt + TW'(1);
            if (hs) wr_valid <= 1'b0;

            if (timeout_hit) begin
                err_valid <= 1'b1;
                err_code  <= E_TIMEOUT;
                wr_valid  <= 1'b0;
                state     <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid && rx_data == SYNC_BYTE) state <= S_CMD;
                    S_CMD: if (rx_valid) begin
                        if (rx_data == CMD_WRITE || rx_data == CMD_START) begin
                            is_write <= (rx_data == CMD_WRITE);
                            state    <= S_ADDR;
`ifdef UART_CMD_CHECKSUM_EN
                            chk      <= rx_data;
`endif
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= E_BAD_CMD;
                            state     <= S_IDLE;
                        end
                    end
                    S_ADDR: if (rx_valid) begin
                        addr_ptr <= rx_data;
                        state    <= S_LEN;
`ifdef UART_CMD_CHECKSUM_EN
                        chk      <= chk ^ rx_data;
`endif
                    end
                    S_LEN: if (rx_valid) begin
`ifdef UART_CMD_CHECKSUM_EN
                        chk   <= chk ^ rx_data;
                        len_q <= rx_data;
                        cnt   <= 8'h00;
`else
                        cnt   <= rx_data;
`endif
                        if (is_write && rx_data != 8'h00 && rx_data <= MAX_LEN_B) begin
                            state <= S_DATA;
                        end else if (!is_write && rx_data == 8'h00) begin
`ifdef UART_CMD_CHECKSUM_EN
                            state <= S_CHK;
`else
                            start_pulse <= 1'b1;
                            frame_done  <= 1'b1;
                            state       <= S_IDLE;
`endif
                        end else begin
                            err_valid <= 1'b1;
                            err_code  <= E_BAD_LEN;
                            state     <= S_IDLE;
                        end
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    S_DATA: if (rx_valid) begin
                        chk <= chk ^ rx_data;
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == len_q) state <= S_CHK;
                    end
                    S_CHK: if (rx_valid) begin
                        if (rx_data != chk) begin
                            err_valid <= 1'b1;
                            err_code  <= E_CHECKSUM;
                            state     <= S_IDLE;
                        end else if (!is_write) begin
                            start_pulse <= 1'b1;
                            frame_done  <= 1'b1;
                            state       <= S_IDLE;
                        end else begin
                            wr_valid <= 1'b1;
                            wr_addr  <= addr_ptr;
                            wr_data  <= pay_buf[0];
                            addr_ptr <= addr_ptr + 8'd1;
                            cnt      <= 8'd1;
                            state    <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (rx_valid) begin
                            err_valid <= 1'b1;
                            err_code  <= E_OVERRUN;
                            wr_valid  <= 1'b0;
                            state     <= S_IDLE;
                        end else if (hs) begin
                            // cnt holds how many buffered bytes have already been presented
                            if (cnt == len_q) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end else begin
                                wr_valid <= 1'b1;
                                wr_addr  <= addr_ptr;
                                wr_data  <= pay_buf[cnt[IW-1:0]];
                                addr_ptr <= addr_ptr + 8'd1;
                                cnt      <= cnt + 8'd1;
                            end
                        end
                    end
`else
                    S_DATA: begin
                        if (rx_valid && wr_valid && !wr_ready) begin
                            err_valid <= 1'b1;
                            err_code  <= E_OVERRUN;
                            wr_valid  <= 1'b0;
                            state     <= S_IDLE;
                        end else begin
                            // cnt counts payload bytes still expected; zero means waiting on the final handshake
                            if (rx_valid && cnt != 8'h00) begin
                                wr_valid <= 1'b1;
                                wr_addr  <= addr_ptr;
                                wr_data  <= rx_data;
                                addr_ptr <= addr_ptr + 8'd1;
                                cnt      <= cnt - 8'd1;
                            end
                            if (hs && cnt == 8'h00) begin
                                frame_done <= 1'b1;
                                state      <= S_IDLE;
                            end
                        end
                    end
`endif
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Randomised scoreboard bench for uart_cmd_ctrl; expectations come from frame-level fields, not byte parsing.
module tb_uart_cmd_ctrl;
    localparam int TO   = 50;
    localparam int MAXL = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       wr_valid;
    logic       wr_ready = 1'b1;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       start_pulse;
    logic       frame_done;
    logic       err_valid;
    logic [2:0] err_code;
    logic       busy;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TO), .SYNC_BYTE(8'hA5), .MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .start_pulse(start_pulse), .frame_done(frame_done), .err_valid(err_valid),
        .err_code(err_code), .busy(busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_wr[$];
    logic [2:0]  exp_err[$];
    int          exp_done = 0, seen_done = 0, exp_start = 0, seen_start = 0;
    int          ready_mode = 0;
    int          cyc = 0;
    logic [7:0]  pay [0:255];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // wr_ready pattern: always, random with a guaranteed accept every 4 cycles, or never
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        case (ready_mode)
            0:       wr_ready = 1'b1;
            1:       wr_ready = (cyc % 4 == 0) || ($urandom_range(0, 1) == 1);
            default: wr_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_valid && wr_ready) begin
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: got %0h, expected none", {wr_addr, wr_data});
                end else begin
                    logic [15:0] e;
                    e = exp_wr.pop_front();
                    checks--;
                    check("write", {wr_addr, wr_data}, e);
                end
            end
            if (err_valid) begin
                checks++;
                if (exp_err.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_error: got %0d, expected none", err_code);
                end else begin
                    logic [2:0] e;
                    e = exp_err.pop_front();
                    checks--;
                    check("err_code", err_code, e);
                end
            end
            if (frame_done)  seen_done++;
            if (start_pulse) seen_start++;
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        repeat (5) @(posedge clk);
    endtask

    task automatic end_frame(input string tag);
        for (int i = 0; i < 400 && (exp_wr.size() != 0 || exp_err.size() != 0 || seen_done != exp_done); i++)
            @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tag, "_writes_left"}, exp_wr.size(), 0);
        check({tag, "_errs_left"}, exp_err.size(), 0);
        check({tag, "_done_count"}, seen_done, exp_done);
        check({tag, "_start_count"}, seen_start, exp_start);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Expected outcome follows from the frame fields alone; then the bytes are sent.
    task automatic run_frame(input logic [7:0] cmd, input logic [7:0] addr, input logic [7:0] len,
                             input bit bad_chk, input string tag);
        logic [7:0] chk;
        bit         ok_len;
        if (cmd != 8'h01 && cmd != 8'h02) begin
            exp_err.push_back(3'd1);
            send(8'hA5); send(cmd);
            end_frame(tag);
            return;
        end
        ok_len = (cmd == 8'h01) ? (len >= 1 && int'(len) <= MAXL) : (len == 0);
        if (!ok_len) begin
            exp_err.push_back(3'd2);
            send(8'hA5); send(cmd); send(addr); send(len);
            end_frame(tag);
            return;
        end
        chk = cmd ^ addr ^ len;
        for (int i = 0; i < int'(len); i++) chk = chk ^ pay[i];
`ifdef UART_CMD_CHECKSUM_EN
        if (bad_chk) exp_err.push_back(3'd5);
`else
        bad_chk = 1'b0;
`endif
        if (!bad_chk) begin
            exp_done++;
            if (cmd == 8'h02) exp_start++;
            else for (int i = 0; i < int'(len); i++) exp_wr.push_back({8'(addr + i), pay[i]});
        end
        send(8'hA5); send(cmd); send(addr); send(len);
        for (int i = 0; i < int'(len); i++) send(pay[i]);
`ifdef UART_CMD_CHECKSUM_EN
        send(bad_chk ? (chk ^ 8'h01) : chk);
`endif
        end_frame(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_wr_valid", wr_valid, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_start", start_pulse, 0);
        check("rst_done", frame_done, 0);
        check("rst_err_valid", err_valid, 0);
        check("rst_err_code", err_code, 0);
        check("rst_busy", busy, 0);

        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        run_frame(8'h01, 8'h10, 8'h03, 1'b0, "write3");
        run_frame(8'h02, 8'h00, 8'h00, 1'b0, "start");
        run_frame(8'h02, 8'h00, 8'h01, 1'b0, "start_badlen");
        check("badlen_code", err_code, 2);

        send(8'h00); send(8'hFF);
        run_frame(8'h07, 8'h00, 8'h00, 1'b0, "badcmd");
        check("badcmd_code", err_code, 1);
        run_frame(8'h02, 8'h00, 8'h00, 1'b0, "start_after_badcmd");

        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        run_frame(8'h01, 8'hFE, 8'h03, 1'b0, "wrap");

`ifndef UART_CMD_CHECKSUM_EN
        ready_mode = 2;
        exp_err.push_back(3'd4);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h02); send(8'h01); send(8'h02);
        @(negedge clk);
        check("overrun_wr_valid", wr_valid, 0);
        check("overrun_code", err_code, 4);
        ready_mode = 0;
        end_frame("overrun");
`endif

        ready_mode = 0;
`ifndef UART_CMD_CHECKSUM_EN
        exp_wr.push_back({8'h00, 8'h01});
`endif
        exp_err.push_back(3'd3);
        send(8'hA5); send(8'h01); send(8'h00); send(8'h02); send(8'h01);
        repeat (TO + 10) @(posedge clk);
        @(negedge clk);
        check("timeout_code", err_code, 3);
        check("timeout_busy", busy, 0);
        end_frame("timeout");

        ready_mode = 2;
        send(8'hA5); send(8'h01); send(8'h00); send(8'h03); send(8'h01);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_wr_valid", wr_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_err_code", err_code, 0);
        ready_mode = 0;
        end_frame("midrst");

`ifdef UART_CMD_CHECKSUM_EN
        pay[0] = 8'h55; pay[1] = 8'h66;
        run_frame(8'h01, 8'h20, 8'h02, 1'b0, "chk_good");
        run_frame(8'h01, 8'h20, 8'h02, 1'b1, "chk_bad");
        check("chk_bad_code", err_code, 5);
`endif

        ready_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int         r;
            logic [7:0] cmd, len;
            r = $urandom_range(0, 9);
            if (r < 6)      cmd = 8'h01;
            else if (r < 8) cmd = 8'h02;
            else            cmd = 8'(3 + $urandom_range(0, 250));
            if (cmd == 8'h01) len = 8'($urandom_range(0, MAXL + 2));
            else              len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 5)) : 8'h00;
            for (int i = 0; i < 256; i++) pay[i] = 8'($urandom);
            run_frame(cmd, 8'($urandom), len, ($urandom_range(0, 4) == 0), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
